// File: rtl/cpu_axi_pkg.sv
// Shared CPU <-> AXI bridge definitions: write type encodings and write-entry field layout.
// Used by the DCache, its posted write buffer and the bridge write path.
package cpu_axi_pkg;

   localparam logic [2:0] WR_TYPE_BYTE = 3'b000;
   localparam logic [2:0] WR_TYPE_HALF = 3'b001;
   localparam logic [2:0] WR_TYPE_WORD = 3'b010;
   localparam logic [2:0] WR_TYPE_LINE = 3'b100;

   localparam int LINE_OFF_W = 4;

   localparam int WR_TYPE_W = 3;
   localparam int WR_ADDR_W = 32;
   localparam int WR_STRB_W = 4;
   localparam int WR_DATA_W = 128;

   // Flattened entry layout, data in the low bits.
   localparam int ENTRY_DATA_LSB = 0;
   localparam int ENTRY_STRB_LSB = ENTRY_DATA_LSB + WR_DATA_W;
   localparam int ENTRY_ADDR_LSB = ENTRY_STRB_LSB + WR_STRB_W;
   localparam int ENTRY_TYPE_LSB = ENTRY_ADDR_LSB + WR_ADDR_W;
   localparam int ENTRY_W        = WR_TYPE_W + WR_ADDR_W + WR_STRB_W + WR_DATA_W;

endpackage

// File: rtl/wb_addr_match.sv
// Purpose: flags a read whose line overlaps one buffered (or incoming) write entry.
// Latency: combinational.  Backpressure: none, pure compare.
module wb_addr_match
   import cpu_axi_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              vld,
   input  logic [2:0]        wr_type,
   input  logic [ADDR_W-1:0] entry_addr,
   input  logic [ADDR_W-1:0] chk_addr,
   output logic              hit
);

   // Reads are whole-line fills, so any write in the same line conflicts regardless
   // of its size or byte offset; type and low offset bits do not affect the result.
   logic unused_bits;
   assign unused_bits = ^{wr_type, entry_addr[LINE_OFF_W-1:0], chk_addr[LINE_OFF_W-1:0]};

   assign hit = vld && (entry_addr[ADDR_W-1:LINE_OFF_W] == chk_addr[ADDR_W-1:LINE_OFF_W]);

endmodule

// File: rtl/dcache_wr_buffer.sv
// Purpose: posted FIFO of DCache line/single writes toward the AXI bridge, plus read hazard check.
// Latency: 1 cycle push-to-head (no bypass); rd_conflict and in_wr_rdy are combinational.
// Backpressure: in_wr_rdy low when full (a same-cycle pop does not free a slot); head held until out_wr_rdy.
module dcache_wr_buffer
   import cpu_axi_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 32
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              in_wr_req,
   input  logic [2:0]        in_wr_type,
   input  logic [ADDR_W-1:0] in_wr_addr,
   input  logic [3:0]        in_wr_wstrb,
   input  logic [127:0]      in_wr_data,
   output logic              in_wr_rdy,
   output logic              out_wr_req,
   output logic [2:0]        out_wr_type,
   output logic [ADDR_W-1:0] out_wr_addr,
   output logic [3:0]        out_wr_wstrb,
   output logic [127:0]      out_wr_data,
   input  logic              out_wr_rdy,
   input  logic [ADDR_W-1:0] rd_chk_addr,
   output logic              rd_conflict,
   output logic              wb_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = 1;
   localparam logic [PTR_W:0]   CNT_ONE  = 1;
   localparam logic [PTR_W:0]   CNT_FULL = DEPTH;

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;
   logic [DEPTH-1:0]  ent_vld;

   logic [2:0]        ent_type  [DEPTH];
   logic [ADDR_W-1:0] ent_addr  [DEPTH];
   logic [3:0]        ent_wstrb [DEPTH];
   logic [127:0]      ent_data  [DEPTH];

   logic              push;
   logic              pop;
   logic [DEPTH:0]    hit;

   // Gated by aresetn so nothing is accepted while the bridge is also held in reset.
   assign in_wr_rdy  = aresetn && (count != CNT_FULL);
   assign push       = in_wr_req && in_wr_rdy;
   assign out_wr_req = ent_vld[rd_ptr];
   assign pop        = out_wr_req && out_wr_rdy;
   assign wb_empty   = (count == '0);

   assign out_wr_type  = ent_type[rd_ptr];
   assign out_wr_addr  = ent_addr[rd_ptr];
   assign out_wr_wstrb = ent_wstrb[rd_ptr];
   assign out_wr_data  = ent_data[rd_ptr];

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ent_vld <= '0;
      end else begin
         if (pop) begin
            rd_ptr          <= rd_ptr + PTR_ONE;
            ent_vld[rd_ptr] <= 1'b0;
         end
         if (push) begin
            wr_ptr          <= wr_ptr + PTR_ONE;
            ent_vld[wr_ptr] <= 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Payload flops need no reset; they are only observed behind ent_vld.
   always_ff @(posedge aclk) begin
      if (push) begin
         ent_type[wr_ptr]  <= in_wr_type;
         ent_addr[wr_ptr]  <= in_wr_addr;
         ent_wstrb[wr_ptr] <= in_wr_wstrb;
         ent_data[wr_ptr]  <= in_wr_data;
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_ent_match
      wb_addr_match #(.ADDR_W(ADDR_W)) u_match (
         .vld        (ent_vld[i]),
         .wr_type    (ent_type[i]),
         .entry_addr (ent_addr[i]),
         .chk_addr   (rd_chk_addr),
         .hit        (hit[i])
      );
   end

   // The write being accepted this cycle is not yet in the array but must still block the read.
   wb_addr_match #(.ADDR_W(ADDR_W)) u_push_match (
      .vld        (push),
      .wr_type    (in_wr_type),
      .entry_addr (in_wr_addr),
      .chk_addr   (rd_chk_addr),
      .hit        (hit[DEPTH])
   );

   assign rd_conflict = |hit;

endmodule

// File: tb/tb_dcache_wr_buffer.sv
// Bench for dcache_wr_buffer: directed scenarios plus random traffic against a queue model.
module tb_dcache_wr_buffer;

   localparam int DEPTH = 2;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic          in_wr_req;
   logic [2:0]    in_wr_type;
   logic [31:0]   in_wr_addr;
   logic [3:0]    in_wr_wstrb;
   logic [127:0]  in_wr_data;
   logic          in_wr_rdy;
   logic          out_wr_req;
   logic [2:0]    out_wr_type;
   logic [31:0]   out_wr_addr;
   logic [3:0]    out_wr_wstrb;
   logic [127:0]  out_wr_data;
   logic          out_wr_rdy;
   logic [31:0]   rd_chk_addr;
   logic          rd_conflict;
   logic          wb_empty;

   always #5 aclk = ~aclk;

   dcache_wr_buffer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .in_wr_req    (in_wr_req),
      .in_wr_type   (in_wr_type),
      .in_wr_addr   (in_wr_addr),
      .in_wr_wstrb  (in_wr_wstrb),
      .in_wr_data   (in_wr_data),
      .in_wr_rdy    (in_wr_rdy),
      .out_wr_req   (out_wr_req),
      .out_wr_type  (out_wr_type),
      .out_wr_addr  (out_wr_addr),
      .out_wr_wstrb (out_wr_wstrb),
      .out_wr_data  (out_wr_data),
      .out_wr_rdy   (out_wr_rdy),
      .rd_chk_addr  (rd_chk_addr),
      .rd_conflict  (rd_conflict),
      .wb_empty     (wb_empty)
   );

   typedef struct {
      logic [2:0]   t;
      logic [31:0]  a;
      logic [3:0]   s;
      logic [127:0] d;
   } wr_t;

   wr_t q[$];
   bit  in_reset;
   int  errors = 0;
   int  checks = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] strb_of(input logic [2:0] t, input logic [31:0] a);
      case (t)
         3'b000:  return 4'b0001 << a[1:0];
         3'b001:  return a[1] ? 4'b1100 : 4'b0011;
         default: return 4'hf;
      endcase
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One clock: drive at posedge+1, check at posedge+5, update the model at the next posedge.
   task automatic step(input string tag, input bit req, input logic [2:0] t,
                       input logic [31:0] a, input logic [127:0] d,
                       input bit ordy, input logic [31:0] chk_a);
      bit   e_rdy;
      bit   e_conf;
      bit   do_push;
      wr_t  w;
      in_wr_req   = req;
      in_wr_type  = t;
      in_wr_addr  = a;
      in_wr_wstrb = strb_of(t, a);
      in_wr_data  = d;
      out_wr_rdy  = ordy;
      rd_chk_addr = chk_a;
      #4;
      e_rdy   = !in_reset && (q.size() != DEPTH);
      do_push = req && e_rdy;
      e_conf  = do_push && (a[31:4] == chk_a[31:4]);
      foreach (q[i]) if (q[i].a[31:4] == chk_a[31:4]) e_conf = 1'b1;
      chk({tag, ".rdy"},   in_wr_rdy,   e_rdy);
      chk({tag, ".req"},   out_wr_req,  q.size() != 0);
      chk({tag, ".empty"}, wb_empty,    q.size() == 0);
      chk({tag, ".conf"},  rd_conflict, e_conf);
      if (q.size() != 0) begin
         chk({tag, ".type"}, out_wr_type,  q[0].t);
         chk({tag, ".addr"}, out_wr_addr,  q[0].a);
         chk({tag, ".strb"}, out_wr_wstrb, q[0].s);
         chk({tag, ".data"}, out_wr_data,  q[0].d);
      end
      @(posedge aclk);
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (do_push) begin
         w.t = t; w.a = a; w.s = strb_of(t, a); w.d = d;
         q.push_back(w);
      end
      #1;
   endtask

   task automatic idle(input string tag, input bit ordy, input logic [31:0] chk_a);
      step(tag, 1'b0, 3'b010, 32'h0, 128'h0, ordy, chk_a);
   endtask

   initial begin
      logic [2:0]  rt;
      logic [31:0] ra;
      aresetn  = 1'b0;
      in_reset = 1'b1;

      // Reset held 5 cycles with a request pending: nothing accepted, no conflict.
      for (int i = 0; i < 5; i++)
         step("rst", 1'b1, 3'b100, 32'h1c00_0040, 128'h1, 1'b0, 32'h1c00_0040);
      aresetn  = 1'b1;
      in_reset = 1'b0;
      idle("rel", 1'b0, 32'h0);

      // Single line write held at the head until accepted.
      step("line_push", 1'b1, 3'b100, 32'h1c00_0040, rnd128(), 1'b0, 32'h0);
      for (int i = 0; i < 10; i++) idle("line_hold", 1'b0, 32'h0);
      idle("line_pop", 1'b1, 32'h0);
      idle("line_done", 1'b0, 32'h0);

      // Fill, reject a third request, then drain in order.
      step("fill0", 1'b1, 3'b010, 32'h0000_0100, rnd128(), 1'b0, 32'h0);
      step("fill1", 1'b1, 3'b100, 32'h0000_0200, rnd128(), 1'b0, 32'h0);
      step("full",  1'b1, 3'b010, 32'h0000_0300, rnd128(), 1'b0, 32'h0);
      idle("drain0", 1'b1, 32'h0);
      idle("drain1", 1'b1, 32'h0);
      idle("drained", 1'b0, 32'h0);

      // Streaming push and pop each cycle at occupancy one.
      step("strm0", 1'b1, 3'b100, 32'h0000_1000, rnd128(), 1'b0, 32'h0);
      for (int i = 1; i <= 20; i++)
         step("strm", 1'b1, 3'b100, 32'h0000_1000 + 32'(16 * i), rnd128(), 1'b1, 32'h0);
      idle("strm_end", 1'b1, 32'h0);
      idle("strm_done", 1'b0, 32'h0);

      // Read hazard against a pending word write, including the push cycle.
      step("haz_push", 1'b1, 3'b010, 32'h1c00_0048, rnd128(), 1'b0, 32'h1c00_0040);
      idle("haz_same", 1'b0, 32'h1c00_0040);
      idle("haz_diff", 1'b0, 32'h1c00_0050);
      idle("haz_pop",  1'b1, 32'h1c00_0044);
      idle("haz_gone", 1'b0, 32'h1c00_0040);

      // Random traffic in a small address window so conflicts are frequent.
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0:       rt = 3'b000;
            1:       rt = 3'b001;
            2:       rt = 3'b010;
            default: rt = 3'b100;
         endcase
         ra = 32'h1c00_0000 | ($urandom_range(0, 7) << 4);
         if (rt == 3'b000)      ra = ra | $urandom_range(0, 15);
         else if (rt == 3'b001) ra = ra | ($urandom_range(0, 7) << 1);
         else if (rt == 3'b010) ra = ra | ($urandom_range(0, 3) << 2);
         step("rnd", $urandom_range(0, 99) < 60, rt, ra, rnd128(),
              $urandom_range(0, 99) < 50,
              32'h1c00_0000 | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15));
      end
      for (int i = 0; i <= DEPTH; i++) idle("rnd_drain", 1'b1, 32'h0);

      // Asynchronous reset between clock edges with two entries buffered.
      step("ar0", 1'b1, 3'b100, 32'h0000_3000, rnd128(), 1'b0, 32'h0000_3000);
      step("ar1", 1'b1, 3'b010, 32'h0000_3104, rnd128(), 1'b0, 32'h0000_3000);
      chk("ar_pre.req", out_wr_req, 1'b1);
      #2;
      aresetn = 1'b0;
      #1;
      in_reset = 1'b1;
      q.delete();
      chk("ar_async.req",   out_wr_req,  1'b0);
      chk("ar_async.empty", wb_empty,    1'b1);
      chk("ar_async.rdy",   in_wr_rdy,   1'b0);
      chk("ar_async.conf",  rd_conflict, 1'b0);
      @(posedge aclk);
      #1;
      idle("ar_hold", 1'b0, 32'h0000_3000);
      aresetn  = 1'b1;
      in_reset = 1'b0;
      step("ar_push", 1'b1, 3'b100, 32'h0000_4000, rnd128(), 1'b0, 32'h0000_4000);
      idle("ar_head", 1'b0, 32'h0000_4000);
      idle("ar_pop",  1'b1, 32'h0);
      idle("ar_done", 1'b0, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
